// File: rtl/serial_mem_ctrl.sv
// Serial-to-parallel memory controller: shifts in address/data beats and issues memory strobes.
// Define SERIAL_READBACK_EN to stream read data back out serially after the parallel return.
module serial_mem_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SER_W  = 1,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ser_valid,
  input  logic [SER_W-1:0]  ser_data,
  input  logic              ser_rw,
  output logic              ser_ready,
  output logic              mem_en,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              sout_valid,
  output logic [SER_W-1:0]  sout_data,
  output logic [CNT_W-1:0]  txn_cnt,
  output logic              busy
);

  localparam int unsigned ABEATS = ADDR_W / SER_W;
  localparam int unsigned DBEATS = DATA_W / SER_W;
  localparam int unsigned CMAX0  = (ABEATS > DBEATS) ? ABEATS : DBEATS;
  localparam int unsigned CMAX   = (CMAX0 > RD_LAT) ? CMAX0 : RD_LAT;
  localparam int unsigned CW     = $clog2(CMAX + 1);
  localparam logic [CW-1:0] A_LAST = CW'(ABEATS - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DBEATS - 1);
  localparam logic [CW-1:0] W_LAST = CW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    ADDR_LOAD, DATA_LOAD, MEM_WRITE, MEM_READ, READ_WAIT, READ_RET, SHIFT_OUT
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [CNT_W-1:0]    r_txn;
  logic                w_accept;
  logic                w_cnt_inc;
  logic                w_capture;
  logic                w_rw;

  assign w_accept  = ser_valid & ser_ready;
  // On the first address beat the direction comes straight from the port.
  assign w_rw      = (r_cnt == '0) ? ser_rw : r_rw;
  assign busy      = ~ser_ready;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rd_data   = r_rdata;
  assign txn_cnt   = r_txn;

  always_comb begin
    w_state_nxt = r_state;
    ser_ready   = 1'b0;
    mem_en      = 1'b0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    rd_valid    = 1'b0;
    sout_valid  = 1'b0;
    w_cnt_inc   = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      ADDR_LOAD: begin
        ser_ready = 1'b1;
        w_cnt_inc = ser_valid;
        if (ser_valid && r_cnt == A_LAST) w_state_nxt = w_rw ? DATA_LOAD : MEM_READ;
      end
      DATA_LOAD: begin
        ser_ready = 1'b1;
        w_cnt_inc = ser_valid;
        if (ser_valid && r_cnt == D_LAST) w_state_nxt = MEM_WRITE;
      end
      MEM_WRITE: begin
        mem_en      = 1'b1;
        mem_wr_en   = 1'b1;
        w_state_nxt = ADDR_LOAD;
      end
      MEM_READ: begin
        mem_en      = 1'b1;
        mem_rd_en   = 1'b1;
        w_state_nxt = READ_WAIT;
      end
      READ_WAIT: begin
        // Enable stays up for RD_LAT-1 cycles; the last wait cycle samples the read data.
        mem_en    = (32'(r_cnt) + 32'd1 < RD_LAT);
        w_cnt_inc = 1'b1;
        if (r_cnt == W_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = READ_RET;
        end
      end
      READ_RET: begin
        rd_valid = 1'b1;
`ifdef SERIAL_READBACK_EN
        w_state_nxt = SHIFT_OUT;
`else
        w_state_nxt = ADDR_LOAD;
`endif
      end
      SHIFT_OUT: begin
`ifdef SERIAL_READBACK_EN
        sout_valid = 1'b1;
        w_cnt_inc  = 1'b1;
        if (r_cnt == D_LAST) w_state_nxt = ADDR_LOAD;
`else
        w_state_nxt = ADDR_LOAD;
`endif
      end
      default: w_state_nxt = ADDR_LOAD;
    endcase
  end

`ifdef SERIAL_READBACK_EN
  logic [DATA_W-1:0] w_sout_word;
  assign w_sout_word = r_rdata << (r_cnt * SER_W);
  assign sout_data   = w_sout_word[DATA_W-1 -: SER_W];
`else
  assign sout_data = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ADDR_LOAD;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (w_cnt_inc)         r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_txn   <= '0;
    end else begin
      if (w_accept && r_state == ADDR_LOAD) begin
        r_addr <= (r_addr << SER_W) | ADDR_W'(ser_data);
        if (r_cnt == '0) r_rw <= ser_rw;
      end
      if (w_accept && r_state == DATA_LOAD) r_wdata <= (r_wdata << SER_W) | DATA_W'(ser_data);
      if (w_capture)                        r_rdata <= mem_rdata;
      if (mem_wr_en || mem_rd_en)           r_txn   <= r_txn + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_serial_mem_ctrl.sv
// Randomized bench for serial_mem_ctrl: a behavioural memory model predicts strobes and read returns.
// Two instances share stimulus so the 2-bit and 8-bit transaction counters are checked together.
module tb_serial_mem_ctrl;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 4;
  localparam int unsigned RL = 2;
  localparam int unsigned NB = DW / SW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ser_valid = 1'b0;
  logic [SW-1:0] ser_data = '0;
  logic          ser_rw = 1'b0;
  logic [DW-1:0] mem_rdata;

  logic          ser_ready, busy, mem_en, mem_wr_en, mem_rd_en, rd_valid, sout_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, rd_data;
  logic [SW-1:0] sout_data;
  logic [1:0]    txn_cnt;

  logic          ser_ready_b, busy_b, mem_en_b, mem_wr_en_b, mem_rd_en_b, rd_valid_b, sout_valid_b;
  logic [AW-1:0] mem_addr_b;
  logic [DW-1:0] mem_wdata_b, rd_data_b;
  logic [SW-1:0] sout_data_b;
  logic [7:0]    txn_cnt_b;

  serial_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SER_W(SW), .RD_LAT(RL), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .ser_valid(ser_valid), .ser_data(ser_data), .ser_rw(ser_rw),
    .ser_ready(ser_ready), .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rd_valid(rd_valid),
    .rd_data(rd_data), .sout_valid(sout_valid), .sout_data(sout_data), .txn_cnt(txn_cnt),
    .busy(busy)
  );

  serial_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SER_W(SW), .RD_LAT(RL), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .ser_valid(ser_valid), .ser_data(ser_data), .ser_rw(ser_rw),
    .ser_ready(ser_ready_b), .mem_en(mem_en_b), .mem_wr_en(mem_wr_en_b),
    .mem_rd_en(mem_rd_en_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata), .rd_valid(rd_valid_b), .rd_data(rd_data_b),
    .sout_valid(sout_valid_b), .sout_data(sout_data_b), .txn_cnt(txn_cnt_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // Memory attached to the DUT: two-cycle read pipeline, noise on the bus when not reading.
  logic [DW-1:0] ram [256];
  logic [DW-1:0] rd_pipe;
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_wdata;
    rd_pipe   <= mem_rd_en ? ram[mem_addr] : DW'($urandom);
    mem_rdata <= rd_pipe;
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [256];
  logic [AW-1:0] wlist[$];
  int            n_txn;
  logic [DW-1:0] last_rd;
  int            total = 0;
  int            bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input bit rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input int gmin, input int gmax);
    logic [SW-1:0] beats[$];
    logic [DW-1:0] exp;
    logic [SW-1:0] nib;
    int            gap;
    beats = {addr[7:4], addr[3:0]};
    if (rw) for (int i = NB - 1; i >= 0; i--) beats.push_back(data[i*SW +: SW]);
    for (int i = 0; i < beats.size(); i++) begin
      gap = (i == 0) ? 0 : int'($urandom_range(gmax, gmin));
      for (int g = 0; g < gap; g++) begin
        ser_valid = 1'b0; ser_data = SW'($urandom); ser_rw = 1'($urandom);
        tick();
        total++;
        if ({ser_ready, mem_en, rd_valid} !== 3'b100) begin
          bad++; $display("FAIL stall_idle ready,en,rdv=%b want 100", {ser_ready, mem_en, rd_valid});
        end
      end
      ser_valid = 1'b1; ser_data = beats[i];
      ser_rw = (i == 0) ? rw : 1'($urandom);
      total++;
      if (ser_ready !== 1'b1) begin
        bad++; $display("FAIL beat_ready beat=%0d got=%b want 1", i, ser_ready);
      end
      tick();
    end
    ser_valid = 1'b0; ser_data = SW'($urandom); ser_rw = 1'($urandom);
    n_txn++;
    if (rw) begin
      total++;
      if ({mem_en, mem_wr_en, mem_rd_en, ser_ready, busy} !== 5'b11001) begin
        bad++; $display("FAIL wr_strobe en,wr,rd,rdy,busy=%b want 11001",
                        {mem_en, mem_wr_en, mem_rd_en, ser_ready, busy});
      end
      total++;
      if ({mem_addr, mem_wdata} !== {addr, data}) begin
        bad++; $display("FAIL wr_addr_data got=%h/%h want %h/%h", mem_addr, mem_wdata, addr, data);
      end
      ref_mem[addr] = data;
      wlist.push_back(addr);
      tick();
      total++;
      if ({mem_en, mem_wr_en, ser_ready} !== 3'b001) begin
        bad++; $display("FAIL wr_done en,wr,rdy=%b want 001", {mem_en, mem_wr_en, ser_ready});
      end
    end else begin
      exp = ref_mem[addr];
      total++;
      if ({mem_en, mem_wr_en, mem_rd_en, ser_ready, busy, mem_addr} !== {5'b10101, addr}) begin
        bad++; $display("FAIL rd_strobe en,wr,rd,rdy,busy=%b addr=%h want 10101 %h",
                        {mem_en, mem_wr_en, mem_rd_en, ser_ready, busy}, mem_addr, addr);
      end
      for (int k = 1; k <= RL; k++) begin
        tick();
        total++;
        if ({mem_en, mem_wr_en, mem_rd_en, rd_valid, ser_ready} !== {(k < RL), 4'b0000}) begin
          bad++; $display("FAIL rd_wait k=%0d en,wr,rd,rdv,rdy=%b want %b", k,
                          {mem_en, mem_wr_en, mem_rd_en, rd_valid, ser_ready}, {(k < RL), 4'b0000});
        end
      end
      tick();
      total++;
      if ({rd_valid, ser_ready, mem_en, rd_data} !== {3'b100, exp}) begin
        bad++; $display("FAIL rd_ret rdv,rdy,en=%b data=%h want 100 %h",
                        {rd_valid, ser_ready, mem_en}, rd_data, exp);
      end
      last_rd = exp;
      tick();
`ifdef SERIAL_READBACK_EN
      for (int j = 0; j < NB; j++) begin
        nib = exp[DW-1-j*SW -: SW];
        total++;
        if ({sout_valid, ser_ready, rd_valid, sout_data} !== {3'b100, nib}) begin
          bad++; $display("FAIL shift_out j=%0d sv,rdy,rdv=%b data=%h want 100 %h", j,
                          {sout_valid, ser_ready, rd_valid}, sout_data, nib);
        end
        tick();
      end
`endif
      total++;
      if ({ser_ready, rd_valid, sout_valid, sout_data, mem_en} !== {3'b100, {SW{1'b0}}, 1'b0}) begin
        bad++; $display("FAIL rd_done rdy,rdv,sv=%b sdata=%h en=%b want 100 0 0",
                        {ser_ready, rd_valid, sout_valid}, sout_data, mem_en);
      end
    end
    total++;
    if ({txn_cnt, txn_cnt_b} !== {2'(n_txn), 8'(n_txn)}) begin
      bad++; $display("FAIL txn_cnt got=%0d/%0d want %0d/%0d", txn_cnt, txn_cnt_b,
                      2'(n_txn), 8'(n_txn));
    end
    total++;
    if (rd_data !== last_rd) begin
      bad++; $display("FAIL rd_hold got=%h want %h", rd_data, last_rd);
    end
    total++;
    if ({ser_ready, busy, mem_en, mem_addr, mem_wdata, rd_data, sout_valid} !==
        {ser_ready_b, busy_b, mem_en_b, mem_addr_b, mem_wdata_b, rd_data_b, sout_valid_b}) begin
      bad++; $display("FAIL inst_agree addr=%h/%h wdata=%h/%h", mem_addr, mem_addr_b,
                      mem_wdata, mem_wdata_b);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    total++;
    if ({ser_ready, busy, mem_en, mem_wr_en, mem_rd_en, rd_valid, sout_valid} !== 7'b1000000) begin
      bad++; $display("FAIL reset_flags got=%b want 1000000",
                      {ser_ready, busy, mem_en, mem_wr_en, mem_rd_en, rd_valid, sout_valid});
    end
    tick(); tick();
    total++;
    if ({mem_addr, mem_wdata, rd_data, txn_cnt, txn_cnt_b, sout_data} !== '0 || ser_ready !== 1'b1) begin
      bad++; $display("FAIL reset_regs addr=%h wd=%h rd=%h cnt=%0d/%0d rdy=%b want 0s rdy=1",
                      mem_addr, mem_wdata, rd_data, txn_cnt, txn_cnt_b, ser_ready);
    end
    reset = 1'b0;
    n_txn = 0;
    last_rd = '0;
  endtask

  task automatic test_write();
    do_txn(1'b1, 8'hA5, 16'h1234, 0, 0);
  endtask

  task automatic test_read();
    do_txn(1'b1, 8'hA5, 16'hBEEF, 0, 0);
    do_txn(1'b0, 8'hA5, 16'h0000, 0, 0);
  endtask

  task automatic test_stall();
    do_txn(1'b1, 8'hA5, 16'h1234, 3, 3);
    do_txn(1'b0, 8'hA5, 16'h0000, 1, 3);
  endtask

  task automatic test_reset_mid();
    logic [SW-1:0] pre[3];
    pre[0] = 4'hA; pre[1] = 4'h5; pre[2] = 4'h1;
    for (int i = 0; i < 3; i++) begin
      ser_valid = 1'b1; ser_data = pre[i]; ser_rw = 1'b1;
      tick();
    end
    ser_data = 4'h2;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({ser_ready, mem_en, mem_wr_en, txn_cnt, txn_cnt_b, mem_addr, mem_wdata, rd_data} !==
        {3'b100, 2'b00, 8'h00, {AW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}}) begin
      bad++; $display("FAIL reset_mid rdy,en,wr=%b cnt=%0d addr=%h wd=%h rd=%h want 100 0s",
                      {ser_ready, mem_en, mem_wr_en}, txn_cnt, mem_addr, mem_wdata, rd_data);
    end
    tick();
    ser_valid = 1'b0;
    reset = 1'b0;
    n_txn = 0;
    last_rd = '0;
    tick();
    total++;
    if ({ser_ready, mem_en, mem_wr_en} !== 3'b100) begin
      bad++; $display("FAIL reset_mid_idle rdy,en,wr=%b want 100", {ser_ready, mem_en, mem_wr_en});
    end
    do_txn(1'b1, 8'h3C, 16'hCAFE, 0, 0);
    do_txn(1'b0, 8'h3C, 16'h0000, 0, 0);
  endtask

  task automatic test_wrap();
    logic [1:0] seq[5];
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_txn = 0;
    last_rd = '0;
    for (int i = 0; i < 5; i++) begin
      do_txn(1'b1, AW'($urandom), DW'($urandom), 0, 1);
      total++;
      if (txn_cnt !== seq[i]) begin
        bad++; $display("FAIL wrap_seq i=%0d got=%0d want %0d", i, txn_cnt, seq[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    bit            rw;
    for (int n = 0; n < 40; n++) begin
      rw = (wlist.size() == 0) ? 1'b1 : 1'($urandom);
      a  = rw ? AW'($urandom) : wlist[$urandom_range(wlist.size() - 1, 0)];
      do_txn(rw, a, DW'($urandom), 0, 2);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    for (int n = 0; n < 8; n++) begin
      a = AW'($urandom);
      do_txn(1'b1, a, DW'($urandom), 0, 0);
      do_txn(1'b0, a, '0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_reset_mid();
    test_wrap();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
